// File: rtl/reg_file_mp_if.sv
// Bundle carrying the register-file read, write, issue and scoreboard signals between the pipeline and the register file.
// Latency: none; this is wiring only.
// Backpressure: none; stalls come from rs_busy, which decode acts on.
interface reg_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]    rs_sel;
  logic [NREAD*XLEN-1:0]  rs_data;
  logic [NREAD-1:0]       rs_busy;
  logic [NWRITE*AW-1:0]   rd_sel;
  logic [NWRITE*XLEN-1:0] wb_data;
  logic [NWRITE-1:0]      reg_write;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic [NREGS-1:0]       busy_vec;

  // Pipeline side: decode and writeback.
  modport master (
    output rs_sel, rd_sel, wb_data, reg_write, issue_valid, issue_rd,
    input  rs_data, rs_busy, busy_vec
  );

  // Register file side.
  modport slave (
    input  rs_sel, rd_sel, wb_data, reg_write, issue_valid, issue_rd,
    output rs_data, rs_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
// Latency: reads are combinational; writes and scoreboard updates take effect on the next rising clk edge.
// Backpressure: none internally; rs_busy tells decode to stall on a source with an in-flight producer.
module reg_file_mp #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  // Bit i is set when at least one enabled write port targets register i this cycle.
  logic [NREGS-1:0] wr_hit;

  // Apply writes in ascending port order, so the highest-numbered port wins a collision.
  always_comb begin
    logic [AW-1:0] dst;
    dst    = '0;
    regs_d = regs_q;
    wr_hit = '0;
    for (int p = 0; p < NWRITE; p++) begin
      dst = bus.rd_sel[p*AW +: AW];
      if (bus.reg_write[p] && dst != '0) begin
        regs_d[dst] = bus.wb_data[p*XLEN +: XLEN];
        wr_hit[dst] = 1'b1;
      end
    end
    regs_d[0] = '0;
    wr_hit[0] = 1'b0;
  end

  // Scoreboard next state: a new issue supersedes a retiring write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (bus.issue_valid && bus.issue_rd == AW'(i)) begin
        busy_d[i] = 1'b1;
      end else if (wr_hit[i]) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Read ports: array read, optionally overridden by the highest-numbered same-cycle writer.
  always_comb begin
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] data;
    logic            bsy;
    sel         = '0;
    data        = '0;
    bsy         = 1'b0;
    bus.rs_data = '0;
    bus.rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      sel  = bus.rs_sel[k*AW +: AW];
      data = regs_q[sel];
      bsy  = busy_q[sel];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWRITE; p++) begin
          if (bus.reg_write[p] && bus.rd_sel[p*AW +: AW] == sel) begin
            data = bus.wb_data[p*XLEN +: XLEN];
          end
        end
        // The value is forwarded this cycle, so the consumer need not stall.
        if (wr_hit[sel]) begin
          bsy = 1'b0;
        end
      end
      if (sel == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
      bus.rs_data[k*XLEN +: XLEN] = data;
      bus.rs_busy[k]              = bsy;
    end
  end

  assign bus.busy_vec = busy_q;

  // State registers; reset drops every pending write and issue immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (INIT_INDEX != 0 && i != 0) ? XLEN'(i) : '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a bypassing and a non-bypassing instance share one stimulus stream.
// Latency: outputs checked #1 after inputs change (combinational) and #1 after each rising edge (state).
// Backpressure: not applicable; the bench drives every cycle.
module tb_reg_file_mp;
  localparam int NR = 32;
  localparam int NW = 2;

  logic clk;
  logic reset;

  reg_file_mp_if #(.XLEN(32), .NREGS(NR), .NREAD(2), .NWRITE(NW)) bif_byp ();
  reg_file_mp_if #(.XLEN(32), .NREGS(NR), .NREAD(2), .NWRITE(NW)) bif_nob ();

  reg_file_mp #(.XLEN(32), .NREGS(NR), .NREAD(2), .NWRITE(NW), .BYPASS(1), .INIT_INDEX(1))
    u_byp (.clk(clk), .reset(reset), .bus(bif_byp));
  reg_file_mp #(.XLEN(32), .NREGS(NR), .NREAD(2), .NWRITE(NW), .BYPASS(0), .INIT_INDEX(1))
    u_nob (.clk(clk), .reset(reset), .bus(bif_nob));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables, copied onto both interfaces by apply().
  logic [4:0]  sel [2];
  logic        we  [NW];
  logic [4:0]  rd  [NW];
  logic [31:0] wd  [NW];
  logic        iv;
  logic [4:0]  ird;

  // Reference model: architectural register contents and scoreboard.
  logic [31:0] mreg  [NR];
  bit          mbusy [NR];

  int npass  = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bif_byp.rs_sel      = {sel[1], sel[0]};
    bif_byp.reg_write   = {we[1], we[0]};
    bif_byp.rd_sel      = {rd[1], rd[0]};
    bif_byp.wb_data     = {wd[1], wd[0]};
    bif_byp.issue_valid = iv;
    bif_byp.issue_rd    = ird;
    bif_nob.rs_sel      = {sel[1], sel[0]};
    bif_nob.reg_write   = {we[1], we[0]};
    bif_nob.rd_sel      = {rd[1], rd[0]};
    bif_nob.wb_data     = {wd[1], wd[0]};
    bif_nob.issue_valid = iv;
    bif_nob.issue_rd    = ird;
  endtask

  task automatic idle();
    for (int p = 0; p < NW; p++) begin
      we[p] = 1'b0;
      rd[p] = '0;
      wd[p] = '0;
    end
    iv  = 1'b0;
    ird = '0;
  endtask

  function automatic bit written(input int s);
    bit w;
    w = 1'b0;
    for (int p = 0; p < NW; p++) begin
      if (we[p] && int'(rd[p]) == s && s != 0) w = 1'b1;
    end
    return w;
  endfunction

  // Value of the newest write to s this cycle: scan from the highest-priority port down.
  function automatic logic [31:0] newest(input int s, input logic [31:0] dflt);
    logic [31:0] r;
    bit found;
    r = dflt;
    found = 1'b0;
    for (int p = NW - 1; p >= 0; p--) begin
      if (!found && we[p] && int'(rd[p]) == s) begin
        r = wd[p];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int s, input bit byp);
    if (s == 0) return 32'h0;
    if (byp) return newest(s, mreg[s]);
    return mreg[s];
  endfunction

  function automatic logic [31:0] exp_busy(input int s, input bit byp);
    if (s == 0) return 32'h0;
    return {31'h0, mbusy[s] && !(byp && written(s))};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    for (int i = 0; i < NR; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mreg[i]  = 32'(i);
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 1; i < NR; i++) begin
      if (iv && int'(ird) == i) mbusy[i] = 1'b1;
      else if (written(i))      mbusy[i] = 1'b0;
      if (written(i)) mreg[i] = newest(i, mreg[i]);
    end
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_byp_d0"}, bif_byp.rs_data[31:0],  exp_data(int'(sel[0]), 1'b1));
    chk({tag, "_byp_d1"}, bif_byp.rs_data[63:32], exp_data(int'(sel[1]), 1'b1));
    chk({tag, "_nob_d0"}, bif_nob.rs_data[31:0],  exp_data(int'(sel[0]), 1'b0));
    chk({tag, "_nob_d1"}, bif_nob.rs_data[63:32], exp_data(int'(sel[1]), 1'b0));
    chk({tag, "_byp_b0"}, {31'h0, bif_byp.rs_busy[0]}, exp_busy(int'(sel[0]), 1'b1));
    chk({tag, "_byp_b1"}, {31'h0, bif_byp.rs_busy[1]}, exp_busy(int'(sel[1]), 1'b1));
    chk({tag, "_nob_b0"}, {31'h0, bif_nob.rs_busy[0]}, exp_busy(int'(sel[0]), 1'b0));
    chk({tag, "_nob_b1"}, {31'h0, bif_nob.rs_busy[1]}, exp_busy(int'(sel[1]), 1'b0));
  endtask

  // Apply inputs, check combinational outputs, clock once, check scoreboard, return at the falling edge.
  task automatic step(input string tag);
    apply();
    #1;
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, "_vec_byp"}, bif_byp.busy_vec, exp_vec());
    chk({tag, "_vec_nob"}, bif_nob.busy_vec, exp_vec());
    @(negedge clk);
  endtask

  initial begin
    idle();
    sel[0] = 5'd1;
    sel[1] = 5'd2;
    apply();
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    #2;
    check_comb("rst12");
    chk("rst_vec", bif_byp.busy_vec, 32'h0);
    chk("rst12_d0", bif_byp.rs_data[31:0], 32'd1);
    chk("rst12_d1", bif_nob.rs_data[63:32], 32'd2);
    sel[0] = 5'd3;
    sel[1] = 5'd6;
    apply();
    #1;
    check_comb("rst36");
    chk("rst36_d1", bif_byp.rs_data[63:32], 32'd6);
    @(negedge clk);
    reset = 1'b0;

    // Single write with a same-cycle read of the destination.
    sel[0] = 5'd7; sel[1] = 5'd0;
    we[0] = 1'b1; rd[0] = 5'd7; wd[0] = 32'h12345678;
    apply();
    #1;
    chk("wr7_byp_same", bif_byp.rs_data[31:0], 32'h12345678);
    chk("wr7_nob_same", bif_nob.rs_data[31:0], 32'd7);
    step("wr7");
    idle();
    apply();
    #1;
    chk("wr7_nob_after", bif_nob.rs_data[31:0], 32'h12345678);

    // Colliding writes, then a write to x0.
    sel[0] = 5'd15;
    we[0] = 1'b1; rd[0] = 5'd15; wd[0] = 32'hDEADBEEF;
    we[1] = 1'b1; rd[1] = 5'd15; wd[1] = 32'hCAFEBABE;
    step("coll15");
    idle();
    sel[0] = 5'd0; sel[1] = 5'd15;
    we[0] = 1'b1; rd[0] = 5'd0; wd[0] = 32'hFFFFFFFF;
    apply();
    #1;
    chk("x0_byp_same", bif_byp.rs_data[31:0], 32'h0);
    chk("r15_nob", bif_nob.rs_data[63:32], 32'hCAFEBABE);
    step("wrx0");
    idle();
    apply();
    #1;
    chk("x0_nob_after", bif_nob.rs_data[31:0], 32'h0);

    // Issue then retire register 5.
    iv = 1'b1; ird = 5'd5;
    step("iss5");
    chk("iss5_vec", bif_byp.busy_vec, 32'h0000_0020);
    idle();
    sel[0] = 5'd5;
    apply();
    #1;
    chk("rd5_busy_byp", {31'h0, bif_byp.rs_busy[0]}, 32'd1);
    step("rd5");
    we[0] = 1'b1; rd[0] = 5'd5; wd[0] = 32'hA5;
    apply();
    #1;
    chk("wb5_busy_byp", {31'h0, bif_byp.rs_busy[0]}, 32'd0);
    chk("wb5_data_byp", bif_byp.rs_data[31:0], 32'hA5);
    chk("wb5_busy_nob", {31'h0, bif_nob.rs_busy[0]}, 32'd1);
    step("wb5");
    chk("wb5_vec", bif_byp.busy_vec, 32'h0);

    // Issue and write the same register in one cycle; issue to x0.
    idle();
    iv = 1'b1; ird = 5'd9;
    we[0] = 1'b1; rd[0] = 5'd9; wd[0] = 32'h99;
    step("iss9wb9");
    chk("iss9_vec", bif_nob.busy_vec, 32'h0000_0200);
    idle();
    sel[0] = 5'd9;
    iv = 1'b1; ird = 5'd0;
    apply();
    #1;
    chk("r9_nob", bif_nob.rs_data[31:0], 32'h99);
    step("iss0");
    chk("iss0_vec", bif_byp.busy_vec, 32'h0000_0200);

    // Pending issues and a write, then an asynchronous reset between edges.
    idle();
    iv = 1'b1; ird = 5'd3;
    we[1] = 1'b1; rd[1] = 5'd3; wd[1] = 32'h333;
    step("iss3");
    idle();
    iv = 1'b1; ird = 5'd4;
    sel[0] = 5'd3;
    step("iss4");
    idle();
    apply();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst_vec_byp", bif_byp.busy_vec, 32'h0);
    chk("arst_vec_nob", bif_nob.busy_vec, 32'h0);
    chk("arst_r3_byp", bif_byp.rs_data[31:0], 32'd3);
    chk("arst_r3_nob", bif_nob.rs_data[31:0], 32'd3);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic concentrated on a few registers so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) sel[k] = 5'($urandom_range(0, 9));
      for (int p = 0; p < NW; p++) begin
        we[p] = 1'($urandom_range(0, 1));
        rd[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
        wd[p] = $urandom;
      end
      iv  = 1'($urandom_range(0, 1));
      ird = 5'($urandom_range(0, 9));
      if (c == 250) begin
        apply();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("rnd_arst_vec", bif_byp.busy_vec, 32'h0);
        @(negedge clk);
        reset = 1'b0;
      end
      step("rnd");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
